// File: rtl/over_if.sv
// Keypad/umpire-to-scoreboard bundle for the over controller.
// The master drives the delivery inputs, and the slave (the controller) drives the innings outputs.
interface over_if #(
  parameter int OVER_W = 5
);
  logic              start_innings;
  logic              ball_bowled;
  logic              is_wide;
  logic              is_no_ball;
  logic              wicket;
  logic [2:0]        ball_in_over;
  logic [OVER_W-1:0] over_count;
  logic [3:0]        wickets;
  logic [7:0]        extras;
  logic              free_hit;
  logic              bowler_end;
  logic              over_done;
  logic              innings_done;
  logic              dropped;
  logic [1:0]        state;

  modport master (
    output start_innings, ball_bowled, is_wide, is_no_ball, wicket,
    input  ball_in_over, over_count, wickets, extras, free_hit,
           bowler_end, over_done, innings_done, dropped, state
  );

  modport slave (
    input  start_innings, ball_bowled, is_wide, is_no_ball, wicket,
    output ball_in_over, over_count, wickets, extras, free_hit,
           bowler_end, over_done, innings_done, dropped, state
  );
endinterface

// File: rtl/over_controller.sv
// Innings ball/over sequencer: qualifies deliveries, closes overs, times change-of-ends
// breaks and ends the innings on the over or wicket limit.
module over_controller #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10,
  parameter int BREAK_CYCLES   = 4,
  parameter int OVER_W         = 5
) (
  input logic  clk,
  input logic  reset,
  over_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] BREAK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int TIMER_W = $clog2(BREAK_CYCLES + 1);

  logic [1:0]         state_q;
  logic               ball_q;
  logic [TIMER_W-1:0] timer_q;
  logic [2:0]         ball_in_over_q;
  logic [OVER_W-1:0]  over_count_q;
  logic [3:0]         wickets_q;
  logic [7:0]         extras_q;
  logic               free_hit_q;
  logic               bowler_end_q;
  logic               over_done_q;
  logic               innings_done_q;
  logic               dropped_q;

  logic               dlv;
  logic               legal;
  logic               wk_inc;
  logic               close;
  logic               ends;
  logic [2:0]         ball_inc;
  logic [OVER_W-1:0]  over_nxt;
  logic [3:0]         wk_nxt;

  // Every limit test uses the post-delivery counts, so a wicket and the
  // over-closing ball that land together are both counted.
  always_comb begin
    dlv      = bus.ball_bowled & ~ball_q;
    legal    = ~bus.is_wide & ~bus.is_no_ball;
    wk_inc   = bus.wicket & ~free_hit_q;
    ball_inc = ball_in_over_q + {2'b00, legal};
    close    = legal & (ball_inc == 3'(BALLS_PER_OVER));
    over_nxt = over_count_q + {{(OVER_W-1){1'b0}}, close};
    wk_nxt   = wickets_q + {3'b000, wk_inc};
    ends     = (over_nxt == OVER_W'(MAX_OVERS)) | (wk_nxt == 4'(MAX_WICKETS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ball_q         <= 1'b0;
      timer_q        <= '0;
      ball_in_over_q <= '0;
      over_count_q   <= '0;
      wickets_q      <= '0;
      extras_q       <= '0;
      free_hit_q     <= 1'b0;
      bowler_end_q   <= 1'b0;
      over_done_q    <= 1'b0;
      innings_done_q <= 1'b0;
      dropped_q      <= 1'b0;
    end else begin
      ball_q         <= bus.ball_bowled;
      over_done_q    <= 1'b0;
      innings_done_q <= 1'b0;
      dropped_q      <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (dlv) dropped_q <= 1'b1;
          if (bus.start_innings) begin
            ball_in_over_q <= '0;
            over_count_q   <= '0;
            wickets_q      <= '0;
            extras_q       <= '0;
            free_hit_q     <= 1'b0;
            bowler_end_q   <= 1'b0;
            state_q        <= PLAY;
          end
        end
        PLAY: begin
          if (dlv) begin
            if (!legal && extras_q != '1) extras_q <= extras_q + 8'd1;
            // A wide takes precedence, so only an undisguised no-ball arms the free hit.
            if (bus.is_no_ball && !bus.is_wide) free_hit_q <= 1'b1;
            else if (legal)                     free_hit_q <= 1'b0;
            wickets_q    <= wk_nxt;
            over_count_q <= over_nxt;
            if (close) begin
              ball_in_over_q <= '0;
              bowler_end_q   <= ~bowler_end_q;
              over_done_q    <= 1'b1;
            end else begin
              ball_in_over_q <= ball_inc;
            end
            if (ends) begin
              state_q        <= DONE;
              innings_done_q <= 1'b1;
            end else if (close) begin
              state_q <= BREAK;
              timer_q <= TIMER_W'(BREAK_CYCLES);
            end
          end
        end
        BREAK: begin
          if (dlv) dropped_q <= 1'b1;
          // Leaving on the cycle the timer would hit zero keeps BREAK at BREAK_CYCLES cycles.
          if (timer_q <= TIMER_W'(1)) begin
            timer_q <= '0;
            state_q <= PLAY;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.ball_in_over = ball_in_over_q;
  assign bus.over_count   = over_count_q;
  assign bus.wickets      = wickets_q;
  assign bus.extras       = extras_q;
  assign bus.free_hit     = free_hit_q;
  assign bus.bowler_end   = bowler_end_q;
  assign bus.over_done    = over_done_q;
  assign bus.innings_done = innings_done_q;
  assign bus.dropped      = dropped_q;
endmodule

// File: tb/tb_over_controller.sv
// Directed and randomized bench for over_controller, checked against an innings-level
// reference model that the bench keeps in plain integers.
module tb_over_controller;
  localparam int BPO = 6;
  localparam int MO  = 2;
  localparam int MW  = 10;
  localparam int BC  = 4;
  localparam int OW  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  over_if #(.OVER_W(OW)) bus ();

  over_controller #(
    .BALLS_PER_OVER(BPO),
    .MAX_OVERS(MO),
    .MAX_WICKETS(MW),
    .BREAK_CYCLES(BC),
    .OVER_W(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference innings state: phase 0 idle, 1 play, 2 break, 3 done.
  int m_phase, m_ball, m_over, m_wk, m_ext, m_fh, m_end;
  int m_od, m_id, m_drop, m_prev, m_brk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ball = 0; m_over = 0; m_wk = 0; m_ext = 0; m_fh = 0; m_end = 0;
    m_od = 0; m_id = 0; m_drop = 0; m_prev = 0; m_brk = 0;
  endtask

  task automatic model(input bit s, input bit bb, input bit w, input bit nb, input bit wk);
    bit dlv;
    bit legal;
    bit closed;
    dlv    = bb && !m_prev;
    m_prev = bb;
    m_od = 0; m_id = 0; m_drop = 0;
    legal  = !w && !nb;
    closed = 0;
    if (m_phase == 0 || m_phase == 3) begin
      if (dlv) m_drop = 1;
      if (s) begin
        m_ball = 0; m_over = 0; m_wk = 0; m_ext = 0; m_fh = 0; m_end = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (dlv) begin
        if (wk && m_fh == 0) m_wk = m_wk + 1;
        if (!legal) m_ext = (m_ext < 255) ? m_ext + 1 : 255;
        if (nb && !w) m_fh = 1;
        else if (legal) m_fh = 0;
        if (legal) begin
          m_ball = m_ball + 1;
          if (m_ball == BPO) begin
            m_ball = 0; m_over = m_over + 1; m_end = 1 - m_end; m_od = 1; closed = 1;
          end
        end
        if (m_over == MO || m_wk == MW) begin
          m_phase = 3; m_id = 1;
        end else if (closed) begin
          m_phase = 2; m_brk = BC;
        end
      end
    end else begin
      if (dlv) m_drop = 1;
      m_brk = m_brk - 1;
      if (m_brk == 0) m_phase = 1;
    end
  endtask

  task automatic check_all();
    chk("state",        bus.state,        m_phase);
    chk("ball_in_over", bus.ball_in_over, m_ball);
    chk("over_count",   bus.over_count,   m_over);
    chk("wickets",      bus.wickets,      m_wk);
    chk("extras",       bus.extras,       m_ext);
    chk("free_hit",     bus.free_hit,     m_fh);
    chk("bowler_end",   bus.bowler_end,   m_end);
    chk("over_done",    bus.over_done,    m_od);
    chk("innings_done", bus.innings_done, m_id);
    chk("dropped",      bus.dropped,      m_drop);
  endtask

  task automatic step(input bit s, input bit bb, input bit w, input bit nb, input bit wk);
    bus.start_innings = s;
    bus.ball_bowled   = bb;
    bus.is_wide       = w;
    bus.is_no_ball    = nb;
    bus.wicket        = wk;
    @(posedge clk);
    model(s, bb, w, nb, wk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // One delivery strobe: high for a cycle, then low.
  task automatic deliver(input bit w, input bit nb, input bit wk);
    step(0, 1, w, nb, wk);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    bus.start_innings = 0; bus.ball_bowled = 0; bus.is_wide = 0;
    bus.is_no_ball = 0; bus.wicket = 0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int brk_cycles;
    reset = 1'b1;
    #2;
    apply_reset();
    chk("rst_state", bus.state, 0);

    // Test 1: six legal balls close the over, followed by a 4-cycle break.
    step(1, 0, 0, 0, 0);
    chk("t1_play", bus.state, 1);
    for (int i = 1; i < BPO; i++) begin
      deliver(0, 0, 0);
      chk("t1_ball", bus.ball_in_over, i);
    end
    step(0, 1, 0, 0, 0);
    chk("t1_over_done", bus.over_done, 1);
    chk("t1_over_count", bus.over_count, 1);
    chk("t1_bowler_end", bus.bowler_end, 1);
    brk_cycles = 1;
    // Test 4: a delivery edge during the break is dropped.
    step(0, 0, 0, 0, 0); brk_cycles++;
    step(0, 1, 0, 0, 0); brk_cycles++;
    chk("t4_dropped", bus.dropped, 1);
    chk("t4_ball", bus.ball_in_over, 0);
    chk("t4_overs", bus.over_count, 1);
    for (int i = 0; i < 10 && bus.state == 2; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.state == 2) brk_cycles++;
    end
    chk("t1_break_len", brk_cycles, BC);
    chk("t1_back_play", bus.state, 1);

    // Test 2: a held strobe counts once.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_held", bus.ball_in_over, 1);

    // Test 3: wide, no-ball, free-hit wicket ignored, then wicket counted.
    deliver(1, 0, 0);
    chk("t3_fh_wide", bus.free_hit, 0);
    deliver(0, 1, 0);
    chk("t3_fh_nb", bus.free_hit, 1);
    deliver(0, 0, 1);
    chk("t3_fh_clear", bus.free_hit, 0);
    chk("t3_wk_free", bus.wickets, 0);
    chk("t3_extras", bus.extras, 2);
    deliver(0, 0, 1);
    chk("t3_wk", bus.wickets, 1);

    // Test 5: the second over ends the innings with both pulses together.
    while (bus.ball_in_over != 3'(BPO - 1)) deliver(0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t5_over_done", bus.over_done, 1);
    chk("t5_innings_done", bus.innings_done, 1);
    chk("t5_done", bus.state, 3);
    step(0, 0, 0, 0, 0);
    chk("t5_no_break", bus.state, 3);
    step(0, 1, 0, 0, 0);
    chk("t5_dropped", bus.dropped, 1);
    step(0, 0, 0, 0, 0);

    // Test 6: ten wickets on legal balls, then restart and mid-over reset.
    step(1, 0, 0, 0, 0);
    chk("t6_restart", bus.wickets, 0);
    for (int i = 0; i < MW; i++) begin
      deliver(0, 0, 1);
      while (bus.state == 2) step(0, 0, 0, 0, 0);
    end
    chk("t6_done", bus.state, 3);
    chk("t6_ball_held", bus.ball_in_over, MW - BPO);
    step(1, 0, 0, 0, 0);
    chk("t6_clear_wk", bus.wickets, 0);
    chk("t6_clear_ov", bus.over_count, 0);
    deliver(0, 0, 0);
    deliver(0, 1, 0);
    apply_reset();
    chk("t6_rst_ball", bus.ball_in_over, 0);

    // Extras saturate at 255.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) deliver(1, 0, 0);
    chk("sat_extras", bus.extras, 255);

    // Randomized deliveries, qualifiers and restarts.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
